// File: rtl/conv_mem_pkg.sv
// Shared defaults and the FSM state type for the convolution-engine memory responder.
package conv_mem_pkg;

  localparam int AW_DEFAULT    = 8;
  localparam int DW_DEFAULT    = 8;
  localparam int DEPTH_DEFAULT = 256;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/conv_mem_array.sv
// DEPTH x DW storage with one write port and a registered read port.
// Contents are deliberately not reset; only the read register is.
module conv_mem_array
  import conv_mem_pkg::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/conv_mem_responder.sv
// Memory responder: engine read/write port plus a streaming preload port.
// Optional access counters are enabled by defining CONV_MEM_ACCESS_COUNT_EN.
module conv_mem_responder
  import conv_mem_pkg::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          read,
  input  logic          write,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] dout,
  output logic [DW-1:0] din,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic [AW-1:0] ld_len,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          busy,
  output logic          err
`ifdef CONV_MEM_ACCESS_COUNT_EN
  ,
  output logic [15:0]   rd_count,
  output logic [15:0]   wr_count
`endif
);

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, cnt;
  logic          beat, load_go, eng_rd, eng_wr, acc_bad;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: if (load_go) state_nxt = LOAD;
      LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        if (ld_valid && cnt == AW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load_go = (state == IDLE) && ld_start && (ld_len != '0);
  assign beat    = ld_ready && ld_valid;
  // Simultaneous read+write: the write wins and the read is dropped.
  assign eng_wr  = (state == IDLE) && write;
  assign eng_rd  = (state == IDLE) && read && !write;
  assign acc_bad = (read && write) || (busy && (read || write));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (load_go) begin
      ptr <= ld_base;
      cnt <= ld_len;
    end else if (beat) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
      cnt <= cnt - AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err <= 1'b0;
    else if (acc_bad) err <= 1'b1;
  end

  // Preload and engine writes are mutually exclusive by state.
  assign mem_we    = beat || eng_wr;
  assign mem_waddr = beat ? ptr : addr;
  assign mem_wdata = beat ? ld_data : dout;

  conv_mem_array #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (eng_rd),
    .raddr (addr),
    .rdata (din)
  );

`ifdef CONV_MEM_ACCESS_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (eng_rd && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (eng_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_mem_responder.sv
// Randomized scoreboard bench for conv_mem_responder against a behavioural memory model.
module tb_conv_mem_responder;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          read = 1'b0, write = 1'b0, ld_start = 1'b0, ld_valid = 1'b0;
  logic [AW-1:0] addr = '0, ld_base = '0, ld_len = '0;
  logic [DW-1:0] dout = '0, ld_data = '0;
  logic [DW-1:0] din;
  logic          ld_ready, busy, err;
`ifdef CONV_MEM_ACCESS_COUNT_EN
  logic [15:0]   rd_count, wr_count;
`endif

  conv_mem_responder #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .dout     (dout),
    .din      (din),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_len   (ld_len),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .busy     (busy),
    .err      (err)
`ifdef CONV_MEM_ACCESS_COUNT_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a plain byte array plus a burst descriptor.
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] m_din;
  logic          m_busy, m_err;
  int            m_ptr, m_left, m_rd, m_wr;

  typedef struct {
    logic [DW-1:0] din;
    logic          busy;
    logic          err;
    int            rdc;
    int            wrc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("din", 32'(din), 32'(e.din));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("ld_ready", 32'(ld_ready), 32'(e.busy));
        chk("err", 32'(err), 32'(e.err));
`ifdef CONV_MEM_ACCESS_COUNT_EN
        chk("rd_count", 32'(rd_count), 32'(e.rdc));
        chk("wr_count", 32'(wr_count), 32'(e.wrc));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic ls, input logic [AW-1:0] lb, input logic [AW-1:0] ll,
                      input logic lv, input logic [DW-1:0] ldat);
    exp_t e;
    @(negedge clk);
    read = r; write = w; addr = a; dout = d;
    ld_start = ls; ld_base = lb; ld_len = ll; ld_valid = lv; ld_data = ldat;
    if (m_busy) begin
      if (r || w) m_err = 1'b1;
      if (lv) begin
        mem_m[m_ptr] = ldat;
        m_ptr  = (m_ptr + 1) % DEPTH;
        m_left = m_left - 1;
        if (m_left == 0) m_busy = 1'b0;
      end
    end else begin
      if (r && w) m_err = 1'b1;
      if (w) begin
        mem_m[a] = d;
        if (m_wr < 65535) m_wr++;
      end else if (r) begin
        m_din = mem_m[a];
        if (m_rd < 65535) m_rd++;
      end
      if (ls && ll != 0) begin
        m_busy = 1'b1;
        m_ptr  = int'(lb);
        m_left = int'(ll);
      end
    end
    e.din = m_din; e.busy = m_busy; e.err = m_err; e.rdc = m_rd; e.wrc = m_wr;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic eng_rd(input logic [AW-1:0] a);
    step(1'b1, 1'b0, a, DW'($urandom), 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic eng_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    read = 1'b0; write = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
    exp_q.delete();
    m_din = '0; m_busy = 1'b0; m_err = 1'b0; m_rd = 0; m_wr = 0; m_left = 0;
    #1;
    chk("rst din", 32'(din), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst ld_ready", 32'(ld_ready), 32'h0);
    chk("rst err", 32'(err), 32'h0);
`ifdef CONV_MEM_ACCESS_COUNT_EN
    chk("rst rd_count", 32'(rd_count), 32'h0);
    chk("rst wr_count", 32'(wr_count), 32'h0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Start a burst, then feed beats (with optional gaps) until the model says it is done
  // or abort_at beats have been accepted. poke issues an engine read mid-burst.
  task automatic do_load(input logic [AW-1:0] base, input logic [AW-1:0] len, input int gap_pct,
                         input int abort_at, input bit poke);
    int   beats;
    logic v, pr, ls;
    beats = 0;
    step(1'b0, 1'b0, '0, '0, 1'b1, base, len, 1'b0, '0);
    while (m_busy && beats != abort_at) begin
      v  = ($urandom_range(0, 99) >= gap_pct);
      pr = poke && (beats == 3);
      ls = ($urandom_range(0, 9) == 0);
      step(pr, 1'b0, AW'($urandom), '0, ls, AW'($urandom), AW'($urandom), v, DW'($urandom));
      if (v) beats++;
    end
  endtask

  initial begin
    int op;
    do_reset();

    for (int i = 0; i < DEPTH; i++) eng_wr(AW'(i), DW'($urandom));

    eng_wr(8'h10, 8'hA5);
    eng_rd(8'h10);
    idle();

    do_load(8'hFE, 8'd4, 0, -1, 1'b0);
    for (int i = 0; i < 4; i++) eng_rd(AW'(254 + i));

    do_load(8'h01, 8'd64, 0, -1, 1'b0);
    for (int i = 0; i < 66; i++) eng_rd(AW'(i));

    for (int i = 0; i < 200; i++) begin
      op = int'($urandom_range(0, 9));
      if (op == 0) do_load(AW'($urandom), AW'($urandom_range(0, 20)), 30, -1, 1'b0);
      else if (op < 5) eng_rd(AW'($urandom));
      else if (op < 9) eng_wr(AW'($urandom), DW'($urandom));
      else idle();
    end

    step(1'b1, 1'b1, 8'h20, 8'h3C, 1'b0, '0, '0, 1'b0, '0);
    idle();
    eng_rd(8'h20);

    do_reset();
    do_load(8'h80, 8'd64, 0, 10, 1'b1);
    do_reset();
    for (int i = 8'h7E; i < 8'h8C; i++) eng_rd(AW'(i));

    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
           ($urandom_range(0, 19) == 0), AW'($urandom), AW'($urandom_range(0, 12)),
           1'($urandom), DW'($urandom));
    end
    for (int i = 0; i < 20; i++) eng_rd(AW'($urandom));

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
